// File: rtl/led_breathe_pwm.sv
// ============================================================================
// led_breathe_pwm
//
// Output stage for the six board LEDs. Takes the active-high lit/unlit
// pattern from the pattern counter, gates it with a PWM whose duty follows
// a free-running triangular "breathing" envelope, and drives the six
// active-low LED pins. New patterns only take effect at PWM period
// boundaries, so a pattern change never produces a partial-period glitch.
//
// Parameters:
//   PWM_BITS      width of the PWM counter and duty register
//                 (PWM period = 2**PWM_BITS clocks)
//   STEP_PERIODS  PWM periods per envelope brightness step (>= 1)
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   pattern        requested LED pattern, 1 = lit
//   pattern_valid  single-cycle strobe, captures pattern
//   enable         1 = breathing, 0 = solid pattern with envelope frozen
//   led            registered active-low LED drive
//   duty           current envelope brightness
//   breathe_dir    envelope direction, 0 = rising, 1 = falling
// ============================================================================
module led_breathe_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 206
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          pattern,
    input  logic                pattern_valid,
    input  logic                enable,
    output logic [5:0]          led,
    output logic [PWM_BITS-1:0] duty,
    output logic                breathe_dir
);

    // A one-period step still needs a 1-bit counter to keep the vector legal.
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [PWM_BITS-1:0] PWM_ZERO = '0;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [STEP_W-1:0]   STEP_END = STEP_W'(STEP_PERIODS - 1);

    typedef enum logic {
        ST_RISE = 1'b0,
        ST_FALL = 1'b1
    } breathe_state_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [5:0]          pattern_pend;
    logic [5:0]          pattern_act;
    breathe_state_t      state;
    breathe_state_t      state_next;
    logic [PWM_BITS-1:0] duty_next;

    logic period_end;
    logic step_tick;
    logic lit;

    // The envelope and pattern hand-over both key off the last cycle of a
    // PWM period, which only exists while the counter is running.
    assign period_end = enable && (pwm_cnt == PWM_MAX);
    assign step_tick  = period_end && (step_cnt == STEP_END);
    assign lit        = (pwm_cnt < duty);

    assign breathe_dir = (state == ST_FALL);

    // PWM counter: free-running while enabled, wraps naturally at the top,
    // frozen in place while disabled so re-enabling resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= PWM_ZERO;
        end else if (enable) begin
            pwm_cnt <= pwm_cnt + PWM_ONE;
        end
    end

    // Step counter: counts completed PWM periods within one brightness step.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (period_end) begin
            if (step_cnt == STEP_END) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

    // Envelope state and duty register. Updating on the edge that ends the
    // step_tick cycle means the new duty starts exactly at pwm_cnt == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RISE;
            duty  <= PWM_ZERO;
        end else begin
            state <= state_next;
            duty  <= duty_next;
        end
    end

    // Triangle envelope: the turn-around steps straight to MAX-1 / 1 so each
    // extreme is shown for exactly one step and duty never wraps.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        if (step_tick) begin
            case (state)
                ST_RISE: begin
                    if (duty == PWM_MAX) begin
                        state_next = ST_FALL;
                        duty_next  = PWM_MAX - PWM_ONE;
                    end else begin
                        duty_next  = duty + PWM_ONE;
                    end
                end
                ST_FALL: begin
                    if (duty == PWM_ZERO) begin
                        state_next = ST_RISE;
                        duty_next  = PWM_ONE;
                    end else begin
                        duty_next  = duty - PWM_ONE;
                    end
                end
                default: begin
                    state_next = ST_RISE;
                    duty_next  = PWM_ZERO;
                end
            endcase
        end
    end

    // Pending pattern: the last strobe seen in a period wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_pend <= 6'h00;
        end else if (pattern_valid) begin
            pattern_pend <= pattern;
        end
    end

    // Active pattern: handed over at the period boundary (or continuously
    // while disabled). A strobe in the hand-over cycle goes straight through
    // so it is not delayed by a whole extra period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_act <= 6'h00;
        end else if (period_end || !enable) begin
            pattern_act <= pattern_valid ? pattern : pattern_pend;
        end
    end

    // Registered active-low drive: PWM-gated while breathing, solid otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 6'h3F;
        end else if (enable) begin
            led <= ~(pattern_act & {6{lit}});
        end else begin
            led <= ~pattern_act;
        end
    end

endmodule

// File: doc/led_breathe_pwm.md
# led_breathe_pwm

Output stage sitting directly downstream of the LED pattern counter on the Tang Nano 9K board. It takes the 6-bit lit/unlit pattern, applies a free-running triangular "breathing" brightness envelope via PWM, and drives the board's six active-low LED pins. Pattern updates are deferred to PWM period boundaries so no partial-period glitches reach the pins.

## Interface

- `PWM_BITS`, default 8: width of the PWM counter and duty register; PWM period is 2^PWM_BITS clocks.
- `STEP_PERIODS`, default 206: PWM periods per brightness step; must be ≥1. At 27 MHz the defaults give about a 1 s full rise+fall.

- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pattern` in 6: requested LED pattern, active-high (1 = LED lit).
- `pattern_valid` in 1: single-cycle strobe. `pattern` is captured on any cycle it is high.
- `enable` in 1: 1 = breathing active; 0 = solid pattern with the envelope frozen.
- `led` out 6: active-low LED drive, registered.
- `duty` out PWM_BITS: current envelope brightness.
- `breathe_dir` out 1: 0 = RISE, 1 = FALL.

## Operation

- **Registers:**
  - `pwm_cnt` (PWM_BITS).
  - `step_cnt` (range 0..STEP_PERIODS-1).
  - `duty`.
  - State RISE/FALL.
  - `pattern_pend`, `pattern_act` (6 bits each).
- **Reset values:**
  - All counters 0, `duty`=0, state RISE, `breathe_dir`=0.
  - `pattern_pend`=`pattern_act`=0.
  - `led`=6'b111111 (all off).
- **`period_end`:** `pwm_cnt`==2^PWM_BITS-1 and `enable`=1.
- **`pwm_cnt`:** increments by 1 every cycle while `enable`=1 and wraps from the maximum to 0. Holds while `enable`=0.
- **`step_cnt`:** increments on `period_end`. When it equals STEP_PERIODS-1 on `period_end`, it resets to 0 and asserts `step_tick` for that cycle.
- **Envelope FSM (acts only on `step_tick`):**
  - RISE, `duty`<MAX: `duty`+1.
  - RISE, `duty`==MAX: go to FALL, `duty`=MAX-1.
  - FALL, `duty`>0: `duty`-1.
  - FALL, `duty`==0: go to RISE, `duty`=1.
  - Extremes are therefore held for exactly one step and never repeated; there is no wrap-around of `duty`.
- **Pattern capture:**
  - `pattern_valid` loads `pattern_pend`.
  - On `period_end`, `pattern_act` loads `pattern_pend`.
  - If `pattern_valid` and `period_end` occur in the same cycle, `pattern_act` loads `pattern` directly, bypassing `pattern_pend`.
  - Several strobes within one period: the last one wins.
  - While `enable`=0, `pattern_act` loads `pattern_pend` every cycle, with the same bypass if `pattern_valid` is high.
- **Lit decision:** `lit` = (`pwm_cnt` < `duty`), an unsigned compare.
  - `duty`=0 gives never lit.
  - `duty`=MAX gives lit for MAX of 2^PWM_BITS cycles.
- **Output:**
  - `enable`=1: `led` <= ~(`pattern_act` & {6{`lit`}}).
  - `enable`=0: `led` <= ~`pattern_act`.
- **Reset mid-operation:** `rst` overrides every other input in the same cycle. The state returns to the reset values, including mid-period and mid-step.

## Timing

- `led` is registered. `led` at edge n+1 reflects `pwm_cnt`, `duty`, `pattern_act` and `enable` sampled at edge n, giving 1-cycle latency.
- **Pattern latency:** the new pattern is first visible on `led` one cycle after the first cycle with `pwm_cnt`==0 that follows the `period_end` at or after the strobe. Worst case is 2^PWM_BITS+1 cycles.
- **Timing of `duty` and `breathe_dir`:** both change on the edge that ends the `step_tick` cycle. The new `duty` therefore applies from `pwm_cnt`==0 of the next period, so every PWM period uses a constant duty.
- **Leaving enable:** `enable` 1→0 freezes `pwm_cnt`, `step_cnt`, `duty` and state. `led` shows the solid pattern from the next edge.
- **Returning to enable:** `enable` 0→1 resumes counting from the frozen values with no restart.
- The first cycle after `rst` deasserts has `pwm_cnt`=0, with `led` still all-ones.

## Test plan

Bench parameters are PWM_BITS=3 and STEP_PERIODS=2 unless noted.

1. **Reset:** hold `rst` 3 cycles with random inputs. Required: `led`=111111, `duty`=0, `breathe_dir`=0, with `pwm_cnt` restarting at 0 on the first cycle after release.
2. **Envelope sweep:** `enable`=1, `pattern`=6'h3F strobed once. Required:
   - `duty` steps 0,1,…,7,6,…,0,1 every 16 clocks.
   - `breathe_dir` rises at `duty` 7→6 and falls at 0→1.
   - `led` is low for exactly `duty` of every 8 cycles in each period.
3. **Deferred pattern:** strobe 6'h15 at `pwm_cnt`=3. Required: `led` keeps the old pattern until the cycle after `pwm_cnt` returns to 0, then shows the 6'h15 mask gated by `lit`.
4. **Simultaneous strobe and boundary:**
   - Strobe 6'h2A at `pwm_cnt`=7, then 6'h01 at `pwm_cnt`=2 of the next period. Required: 6'h2A applies from the immediate next period; 6'h01 only after the following boundary.
   - Two strobes in one period. Required: only the second appears.
5. **Enable freeze:** drop `enable` at `duty`=5 mid-period for 40 cycles. Required:
   - `led`=~`pattern_act` solid.
   - `duty`=5, `pwm_cnt` and `step_cnt` unchanged throughout.
   - After re-enable, counting continues from the frozen `pwm_cnt`.
6. **Reset mid-step:** assert `rst` while FALL with `duty`=4 and `pwm_cnt`=5. Required: the next cycle shows all reset values and `pattern_act`=0, and `led` stays off until a new strobe.
